// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter: sends the low Len bits of Data MSB-first on X,
// optionally repeated with GAP idle cycles between frames. Define PARITY_TX_EN for a trailing even-parity bit.
module pattern_tx #(
  parameter int W   = 8,
  parameter int LW  = 4,
  parameter int GAP = 1
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Start,
  input  logic [W-1:0]  Data,
  input  logic [LW-1:0] Len,
  input  logic [3:0]    Repeat,
  output logic          X,
  output logic          XValid,
  output logic          Busy,
  output logic          Done
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

`ifdef PARITY_TX_EN
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAPW, S_FINISH, S_PAR} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAPW, S_FINISH} state_e;
`endif

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  frame_q, frame_d;
  logic [LW-1:0] len_q,   len_d;
  logic [LW-1:0] cnt_q,   cnt_d;
  logic [3:0]    rep_q,   rep_d;
  logic [GW-1:0] gap_q,   gap_d;
`ifdef PARITY_TX_EN
  logic          parity_q, parity_d;
`endif

  logic [LW-1:0] eff_len;
  logic [LW-1:0] shamt;
  logic          post_frame;

  assign eff_len = (Len == '0 || Len > LW'(W)) ? LW'(W) : Len;
  assign shamt   = LW'(W) - eff_len;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    shreg_d    = shreg_q;
    frame_d    = frame_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    post_frame = 1'b0;
`ifdef PARITY_TX_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          shreg_d = Data << shamt;
          frame_d = Data << shamt;
          len_d   = eff_len;
          cnt_d   = '0;
          rep_d   = Repeat;
          gap_d   = '0;
`ifdef PARITY_TX_EN
          parity_d = 1'b0;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
`ifdef PARITY_TX_EN
        parity_d = parity_q ^ shreg_q[W-1];
        if (cnt_q == len_q - 1'b1) state_d = S_PAR;
`else
        if (cnt_q == len_q - 1'b1) post_frame = 1'b1;
`endif
      end
`ifdef PARITY_TX_EN
      S_PAR: post_frame = 1'b1;
`endif
      S_GAPW: begin
        if (gap_q == GW'(GAP - 1)) begin
          shreg_d = frame_q;
          rep_d   = rep_q - 1'b1;
          cnt_d   = '0;
`ifdef PARITY_TX_EN
          parity_d = 1'b0;
`endif
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Shared end-of-frame branch: another frame (with or without a gap) or finish.
    if (post_frame) begin
      if (rep_q != 4'd0) begin
        if (GAP == 0) begin
          shreg_d = frame_q;
          rep_d   = rep_q - 1'b1;
          cnt_d   = '0;
`ifdef PARITY_TX_EN
          parity_d = 1'b0;
`endif
          state_d = S_SHIFT;
        end else begin
          gap_d   = '0;
          state_d = S_GAPW;
        end
      end else begin
        state_d = S_FINISH;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (Clr) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
`ifdef PARITY_TX_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
`ifdef PARITY_TX_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    X      = 1'b0;
    XValid = 1'b0;
    case (state_q)
      S_SHIFT: begin
        X      = shreg_q[W-1];
        XValid = 1'b1;
      end
`ifdef PARITY_TX_EN
      S_PAR: begin
        X      = parity_q;
        XValid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = (state_q == S_FINISH);

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: table vectors, hand-written corner sequences and
// randomized frames, all compared cycle by cycle against a frame-level reference model.
module tb_pattern_tx;
  localparam int W   = 8;
  localparam int LW  = 4;
  localparam int GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr, start;
  logic [W-1:0]  data;
  logic [LW-1:0] len;
  logic [3:0]    rep;
  logic          x, xvalid, busy, done;

  pattern_tx #(.W(W), .LW(LW), .GAP(GAP)) dut (
    .Clk(clk), .Clr(clr), .Start(start), .Data(data), .Len(len), .Repeat(rep),
    .X(x), .XValid(xvalid), .Busy(busy), .Done(done)
  );

  int tests = 0;
  int fails = 0;

  // Expected per-cycle outputs {X, XValid, Busy, Done}, starting at cycle 1 after acceptance.
  logic [3:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] rep;
    int         done_cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int par_extra(input int r);
`ifdef PARITY_TX_EN
    return r + 1;
`else
    return 0;
`endif
  endfunction

  function automatic void build_model(input logic [7:0] d, input int l, input int r);
    int n;
    bit p;
    n = (l == 0 || l > W) ? W : l;
    exp_q.delete();
    for (int f = 0; f <= r; f++) begin
      p = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
        exp_q.push_back({d[i], 3'b110});
        p ^= d[i];
      end
`ifdef PARITY_TX_EN
      exp_q.push_back({p, 3'b110});
`endif
      if (f < r)
        for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  task automatic run(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                     input int repulse, input bit scramble, output int done_at);
    build_model(d, int'(l), int'(r));
    @(negedge clk);
    data = d; len = l; rep = r; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    done_at = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("data%02h_len%0d_rep%0d_cyc%0d", d, l, r, k + 1),
            {28'd0, x, xvalid, busy, done}, {28'd0, exp_q[k]});
      if (done && done_at < 0) done_at = k + 1;
      start = (k + 1 == repulse);
      if (start) data = 8'hFF;
      if (scramble) begin
        data = 8'($urandom);
        len  = 4'($urandom);
        rep  = 4'($urandom);
      end
    end
  endtask

  vec_t vecs[$];
  int   done_at;
  int   dn;
  bit   seen;

  initial begin
    clr = 1'b1; start = 1'b0; data = '0; len = '0; rep = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, x, xvalid, busy, done}, 32'd0);
    clr = 1'b0;

    vecs.push_back('{8'h0A, 4'd4,  4'd0, 5});
    vecs.push_back('{8'h0A, 4'd4,  4'd2, 15});
    vecs.push_back('{8'hB5, 4'd0,  4'd0, 9});
    vecs.push_back('{8'hB5, 4'd9,  4'd0, 9});
    vecs.push_back('{8'h0B, 4'd4,  4'd0, 5});
    vecs.push_back('{8'h81, 4'd1,  4'd0, 2});
    vecs.push_back('{8'h0A, 4'd2,  4'd1, 6});
    vecs.push_back('{8'h5A, 4'd8,  4'd3, 36});
    vecs.push_back('{8'hC3, 4'd15, 4'd0, 9});
    foreach (vecs[i]) begin
      run(vecs[i].data, vecs[i].len, vecs[i].rep, 0, 1'b0, done_at);
      check($sformatf("done_cycle_vec%0d", i), 32'(done_at),
            32'(vecs[i].done_cyc + par_extra(int'(vecs[i].rep))));
    end

    // Start re-pulsed with different data mid-frame must be ignored.
    run(8'h0A, 4'd4, 4'd0, 2, 1'b0, done_at);
    check("repulse_done_cycle", 32'(done_at), 32'(5 + par_extra(0)));

    // Start held high re-triggers on the first IDLE cycle after FINISH.
    dn = 5 + par_extra(0);
    @(negedge clk);
    data = 8'h0A; len = 4'd4; rep = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    repeat (dn - 1) begin
      @(posedge clk); #1;
    end
    check("held_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("held_idle_gap", {28'd0, x, xvalid, busy, done}, 32'd0);
    @(posedge clk); #1;
    check("held_retrigger", {29'd0, x, xvalid, busy}, 32'd7);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      seen = done;
    end
    check("held_second_done", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;

    // Clr mid-frame aborts with no Done and no trailing bits.
    @(negedge clk);
    data = 8'hA5; len = 4'd8; rep = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_abort", {28'd0, x, xvalid, busy, done}, 32'd0);
    clr  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (x || xvalid || busy || done) seen = 1'b1;
    end
    check("clr_quiet", {31'd0, seen}, 32'd0);
    run(8'hA5, 4'd8, 4'd0, 0, 1'b0, done_at);
    check("after_clr_done_cycle", 32'(done_at), 32'(9 + par_extra(0)));

    // Randomized frames with the inputs scrambled after acceptance.
    for (int t = 0; t < 25; t++) begin
      logic [7:0] rd;
      logic [3:0] rl, rr;
      rd = 8'($urandom);
      rl = 4'($urandom_range(0, 15));
      rr = 4'($urandom_range(0, 3));
      run(rd, rl, rr, 0, 1'b1, done_at);
      check($sformatf("rand%0d_done_cycle", t), 32'(done_at), 32'(exp_q.size() - 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial bit-pattern transmitter: the driving end of the single-bit X serial stream consumed by the Moore sequence detector.
- Latches a parallel word and emits its low Len bits MSB-first on X, one bit per Clk cycle.
- Optionally repeats the frame with idle gaps between frames.
- Pulses Done when finished.
- Used as the stimulus source and loopback partner for the detector.

Parameters:
W, 8, maximum frame length in bits (width of Data).
LW, 4, width of Len; must satisfy 2^LW > W.
GAP, 1, idle cycles inserted between repeated frames (0 = back-to-back).

Ports:
Clk     input   1     clock; all state changes on rising edge.
Clr     input   1     reset, synchronous, active-high.
Start   input   1     request a transmission; sampled only in IDLE.
Data    input   W     pattern word; bits [Len-1:0] are sent, bit Len-1 first.
Len     input   LW    frame length in bits; 0 or >W treated as W.
Repeat  input   4     extra repetitions; total frames = Repeat+1.
X       output  1     serial data bit.
XValid  output  1     1 while X carries a frame bit.
Busy    output  1     1 from the cycle after Start acceptance through the Done cycle.
Done    output  1     one-cycle completion pulse.

Behaviour:
- Reset: Clr=1 at a rising edge forces state IDLE; Clr has priority over all inputs.
  - In the following cycle: X=0, XValid=0, Busy=0, Done=0; shift register, bit counter and repeat counter all cleared.
  - Clr mid-frame aborts immediately; no Done pulse, no partial bits afterwards.
- Outputs are Moore: decoded only from registered state, shift register MSB and counters. No combinational path from any input to any output.
- States: IDLE, SHIFT, GAPW, FINISH (plus PAR when PARITY_EN).
- IDLE:
  - Outputs all 0.
  - Start=1 at edge E0: latch eff_len = (Len==0 || Len>W) ? W : Len.
  - Load shift reg with Data<<(W-eff_len) (frame left-aligned); latch Repeat into rep_left; bit counter = 0; go SHIFT.
- SHIFT:
  - XValid=1, Busy=1, X=shreg[W-1].
  - Each edge: shift left by 1, counter+1.
  - On the edge where counter reaches eff_len-1 (last bit shown):
    - PARITY_EN: go PAR.
    - Else if rep_left!=0: go GAPW, or, if GAP==0, reload shreg from the latched frame and stay SHIFT.
    - Else: go FINISH.
- GAPW:
  - X=0, XValid=0, Busy=1 for exactly GAP cycles.
  - Then reload shreg from the latched copy, rep_left-1, counter=0, go SHIFT.
- FINISH: Done=1, Busy=1, XValid=0, X=0 for one cycle; then IDLE.
- Latency:
  - First frame bit appears in the cycle after E0.
  - Single frame: Done in cycle eff_len+1 after E0.
  - General case: Done at cycle (Repeat+1)*eff_len + Repeat*GAP + 1 (+ Repeat+1 with PARITY_EN).
- Start is ignored whenever state!=IDLE, including during FINISH.
  - Start held high continuously re-triggers in the first IDLE cycle after FINISH.
- Data, Len and Repeat are don't-care except at the accepting edge; later changes have no effect.
- Counters saturate nowhere. rep_left decrements only on GAPW exit or on a GAP==0 reload.

Optional Feature:
Macro PARITY_TX_EN.
- Defined: state PAR follows each frame's last data bit for one cycle.
  - X = even parity (XOR) of the eff_len bits just sent; XValid=1, Busy=1.
  - PAR then takes the post-frame branch (GAPW / reload / FINISH).
- Undefined: no PAR state, no parity logic; frame is data bits only.

Test Plan:
- Len=4, Data=8'h0A, Repeat=0, Start pulse at E0 -> X=1,0,1,0 with XValid=1 in cycles 1-4; Done=1 in cycle 5 only; Busy=1 in cycles 1-5; all outputs 0 in cycle 6.
- Len=4, Data=8'h0A, Repeat=2, GAP=1 -> X/XValid: 1010 (valid), 0 (invalid), 1010, 0, 1010; Done in cycle 15.
- Len=0, Data=8'hB5 -> eight bits 1,0,1,1,0,1,0,1; Done in cycle 9; a repeat with Len=9 produces identical output.
- Start re-pulsed with Data=8'hFF during cycle 2 of a Data=8'h0A, Len=4 frame -> ignored; output still 1010, then Done.
- Clr=1 at the edge ending cycle 2 of an 8-bit frame -> next cycle X=0, XValid=0, Busy=0; Done never asserts; a fresh Start then works normally.
- PARITY_TX_EN, Len=4, Data=8'h0B -> X=1,0,1,1 then parity 1 (XValid=1) in cycle 5; Done in cycle 6. With Data=8'h0A the parity bit is 0.
